info_writer: RTL and testbench
==============================

Name: info_writer

Overview:
- Sits between the SDRAM test engine's status stream (16-bit `info` word plus `info_e` strobe) and the text-mode display's write port (`waddr`/`wdata`/`we`).
- Buffers status words in a small FIFO and clears display memory after reset.
- Places words at sequential display addresses with wrap-around, and flags dropped words.
- Replaces the free-running address counter in the top level.

Parameters:
- ADDR_W, 12, display write address width.
- DEPTH_LOG2, 3, FIFO depth is 2**DEPTH_LOG2 words.
- STEP, 2, address increment per word written.
- LINE_STEP, 64, address span of one display line; must be a power of two and a multiple of STEP.
- CLEAR_VAL, 16'h0000, word written to every location during the clear sweep.

Ports:
- clk  in  1  single clock for stream and display write side.
- rst_n  in  1  asynchronous active-low reset.
- info  in  16  status word from the test engine.
- info_e  in  1  `info` is valid this cycle; no backpressure, one word per cycle max.
- waddr  out  ADDR_W  display write address, registered.
- wdata  out  16  display write data, registered.
- we  out  1  display write strobe, registered, one cycle per write.
- busy  out  1  high while the clear sweep runs.
- overflow  out  1  sticky; a word arrived while the FIFO was full.

Behaviour:
- Reset (async assert, sync deassert handled by the top level): state=CLEAR, sweep pointer=0, write pointer=0, FIFO empty, waddr=0, wdata=0, we=0, busy=1, overflow=0.
- State CLEAR:
  - Each cycle: we=1, waddr=sweep pointer, wdata=CLEAR_VAL, then sweep pointer += STEP.
  - When sweep pointer would wrap past 2**ADDR_W - STEP, the last clear write issues and the state goes to RUN.
  - Total clear writes are 2**ADDR_W/STEP, e.g. 2048 for the defaults.
  - busy deasserts on the first RUN cycle.
- `info_e` during CLEAR pushes to the FIFO normally; words are held until RUN.
- State RUN:
  - If the FIFO is non-empty, pop one word per cycle.
  - On the same clock edge: we=1, waddr=write pointer, wdata=popped word, then write pointer += STEP.
  - If the FIFO is empty: we=0; waddr and wdata hold their last values.
- Latency: a word pushed in an empty FIFO at edge N appears on wdata with we=1 after edge N+1. There is no same-cycle bypass.
- Write pointer arithmetic is modulo 2**ADDR_W: after address 2**ADDR_W - STEP it returns to 0. No re-clear on wrap; old text is overwritten.
- FIFO full with info_e=1 and no pop that cycle: the word is dropped and overflow is set. overflow clears only on reset.
- FIFO full with info_e=1 and a pop in the same cycle: push accepted, no drop, occupancy unchanged.
- FIFO empty with info_e=1: the word is pushed; no pop that cycle.
- Reset mid-operation: all state returns to reset values immediately. A partially issued write is abandoned, FIFO contents are lost, and the clear sweep restarts at 0.

Optional Feature:
- Macro INFO_WRITER_NEWLINE_EN.
- When defined, a popped word equal to 16'hFFFF is a newline marker:
  - No display write; we=0 that cycle.
  - Write pointer advances to the next multiple of LINE_STEP, modulo 2**ADDR_W.
  - If the pointer is already at a line start it still advances one full line.
- When undefined, 16'hFFFF is written to the display like any other word.
- Either way the marker occupies one FIFO pop.

Decomposition:
- Shared package info_writer_pkg:
  - state enum (CLEAR, RUN);
  - NEWLINE_WORD constant 16'hFFFF;
  - default width constants.
- One sub-module, sync_fifo:
  - parameterised width/depth;
  - push/pop/full/empty;
  - async active-low reset;
  - simultaneous push+pop at full is legal.
- The FSM, pointers and output registers live in info_writer.

Test Plan:
- Reset with ADDR_W=6, STEP=2 -> exactly 32 writes of CLEAR_VAL to addresses 0,2,...,62 on consecutive cycles with busy=1; busy=0 on the next cycle and we=0.
- After clear, push 16'h1234 then 16'hABCD on consecutive cycles -> writes (0,1234) one cycle after first push, then (2,ABCD); no further we.
- Push 3 words during CLEAR (DEPTH_LOG2=3) -> held, written to addresses 0,2,4 on the first three RUN cycles in push order; overflow stays 0.
- During CLEAR push 9 consecutive words into depth 8 -> ninth dropped, overflow=1 sticky; first 8 written in order after clear.
- ADDR_W=6: write 33 words after clear -> 33rd word lands at address 0, overwriting the first.
- With INFO_WRITER_NEWLINE_EN, LINE_STEP=16: push 1111, FFFF, 2222 -> writes (0,1111), no write for the marker, then (16,2222). Without the macro: (0,1111), (2,FFFF), (4,2222).

Source files
------------

// File: rtl/info_writer_pkg.sv
// Shared types and constants for the display status writer.
package info_writer_pkg;

  localparam int unsigned DATA_W         = 16;
  localparam int unsigned DEF_ADDR_W     = 12;
  localparam int unsigned DEF_DEPTH_LOG2 = 3;
  localparam int unsigned DEF_STEP       = 2;
  localparam int unsigned DEF_LINE_STEP  = 64;

  localparam logic [DATA_W-1:0] DEF_CLEAR_VAL = 16'h0000;
  localparam logic [DATA_W-1:0] NEWLINE_WORD  = 16'hFFFF;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  function automatic logic is_newline(input logic [DATA_W-1:0] w);
    return w == NEWLINE_WORD;
  endfunction

endpackage

// File: rtl/info_writer_sync_fifo.sv
// Single-clock FIFO; push while full is accepted only when a pop happens the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned DEPTH_LOG2 = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_c,
  output logic             full_c,
  output logic             empty_c
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]    mem_q [DEPTH];
  logic [DEPTH_LOG2:0] rd_q, rd_d;
  logic [DEPTH_LOG2:0] wr_q, wr_d;
  logic                do_pop;
  logic                do_push;

  // Pointers carry one extra wrap bit to tell full from empty.
  assign empty_c = (rd_q == wr_q);
  assign full_c  = (rd_q[DEPTH_LOG2] != wr_q[DEPTH_LOG2]) &&
                   (rd_q[DEPTH_LOG2-1:0] == wr_q[DEPTH_LOG2-1:0]);
  assign data_c  = mem_q[rd_q[DEPTH_LOG2-1:0]];

  assign do_pop  = pop_i && !empty_c;
  assign do_push = push_i && (!full_c || do_pop);

  always_comb begin
    rd_d = rd_q;
    wr_d = wr_q;
    if (do_pop)  rd_d = rd_q + (DEPTH_LOG2+1)'(1);
    if (do_push) wr_d = wr_q + (DEPTH_LOG2+1)'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q <= '0;
      wr_q <= '0;
    end else begin
      rd_q <= rd_d;
      wr_q <= wr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[DEPTH_LOG2-1:0]] <= data_i;
  end

endmodule

// File: rtl/info_writer.sv
// Buffers status words and writes them to sequential display addresses after a clear sweep.
// Optional macro INFO_WRITER_NEWLINE_EN turns popped 16'hFFFF words into line breaks.
module info_writer
  import info_writer_pkg::*;
#(
  parameter int unsigned       ADDR_W     = DEF_ADDR_W,
  parameter int unsigned       DEPTH_LOG2 = DEF_DEPTH_LOG2,
  parameter int unsigned       STEP       = DEF_STEP,
  parameter int unsigned       LINE_STEP  = DEF_LINE_STEP,
  parameter logic [DATA_W-1:0] CLEAR_VAL  = DEF_CLEAR_VAL
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] info,
  input  logic              info_e,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata,
  output logic              we,
  output logic              busy,
  output logic              overflow
);

`ifdef INFO_WRITER_NEWLINE_EN
  localparam bit NEWLINE_EN = 1'b1;
`else
  localparam bit NEWLINE_EN = 1'b0;
`endif

  localparam logic [ADDR_W-1:0] STEP_A     = ADDR_W'(STEP);
  localparam logic [ADDR_W-1:0] LAST_SWEEP = ADDR_W'(0) - STEP_A;
  localparam logic [ADDR_W-1:0] LINE_A     = ADDR_W'(LINE_STEP);
  localparam logic [ADDR_W-1:0] LINE_MASK  = ~ADDR_W'(LINE_STEP - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   sweep_q, sweep_d;
  logic [ADDR_W-1:0]   wptr_q, wptr_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                we_q, we_d;
  logic                busy_q, busy_d;
  logic                ovf_q, ovf_d;

  logic [DATA_W-1:0]   fifo_word_c;
  logic                fifo_full_c;
  logic                fifo_empty_c;
  logic                pop_c;

  assign pop_c = (state_q == ST_RUN) && !fifo_empty_c;

  sync_fifo #(
    .WIDTH      (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (info_e),
    .data_i  (info),
    .pop_i   (pop_c),
    .data_c  (fifo_word_c),
    .full_c  (fifo_full_c),
    .empty_c (fifo_empty_c)
  );

  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    wptr_d  = wptr_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    busy_d  = (state_q == ST_CLEAR);
    ovf_d   = ovf_q | (info_e & fifo_full_c & ~pop_c);

    case (state_q)
      ST_CLEAR: begin
        we_d    = 1'b1;
        waddr_d = sweep_q;
        wdata_d = CLEAR_VAL;
        sweep_d = sweep_q + STEP_A;
        if (sweep_q == LAST_SWEEP) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (pop_c) begin
          // A newline marker moves the pointer to the start of the following line.
          if (NEWLINE_EN && is_newline(fifo_word_c)) begin
            wptr_d = (wptr_q & LINE_MASK) + LINE_A;
          end else begin
            we_d    = 1'b1;
            waddr_d = wptr_q;
            wdata_d = fifo_word_c;
            wptr_d  = wptr_q + STEP_A;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_CLEAR;
      sweep_q <= '0;
      wptr_q  <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      busy_q  <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
      wptr_q  <= wptr_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
    end
  end

  assign waddr    = waddr_q;
  assign wdata    = wdata_q;
  assign we       = we_q;
  assign busy     = busy_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_info_writer.sv
// Bench for info_writer: directed scenarios plus random traffic against a queue-based model.
module tb_info_writer;

  localparam int unsigned ADDR_W     = 6;
  localparam int unsigned DEPTH_LOG2 = 3;
  localparam int unsigned STEP       = 2;
  localparam int unsigned LINE_STEP  = 16;
  localparam logic [15:0] CLEAR_VAL  = 16'h0020;
  localparam int          SPAN       = 1 << ADDR_W;
  localparam int          NCLR       = SPAN / STEP;
  localparam int          DEPTH      = 1 << DEPTH_LOG2;
`ifdef INFO_WRITER_NEWLINE_EN
  localparam bit NL = 1'b1;
`else
  localparam bit NL = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [15:0]       info = '0;
  logic              info_e = 1'b0;
  logic [ADDR_W-1:0] waddr;
  logic [15:0]       wdata;
  logic              we;
  logic              busy;
  logic              overflow;

  info_writer #(
    .ADDR_W     (ADDR_W),
    .DEPTH_LOG2 (DEPTH_LOG2),
    .STEP       (STEP),
    .LINE_STEP  (LINE_STEP),
    .CLEAR_VAL  (CLEAR_VAL)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .info     (info),
    .info_e   (info_e),
    .waddr    (waddr),
    .wdata    (wdata),
    .we       (we),
    .busy     (busy),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  int          n_we  = 0;

  // Reference model: clear progress, pending-word queue, write pointer, expected outputs.
  int          m_clr;
  int          m_ptr;
  logic [15:0] m_q [$];
  logic        exp_we;
  int          exp_addr;
  logic [15:0] exp_data;
  logic        exp_busy;
  logic        exp_ovf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_outputs(input string ph);
    chk({ph, ":we"},       32'(we),       32'(exp_we));
    chk({ph, ":waddr"},    32'(waddr),    32'(exp_addr));
    chk({ph, ":wdata"},    32'(wdata),    32'(exp_data));
    chk({ph, ":busy"},     32'(busy),     32'(exp_busy));
    chk({ph, ":overflow"}, 32'(overflow), 32'(exp_ovf));
  endtask

  task automatic model_edge(input logic e, input logic [15:0] d);
    bit          in_run;
    logic [15:0] w;
    in_run   = (m_clr == NCLR);
    exp_busy = !in_run;
    exp_we   = 1'b0;
    if (!in_run) begin
      exp_we   = 1'b1;
      exp_addr = m_clr * STEP;
      exp_data = CLEAR_VAL;
      m_clr++;
    end else if (m_q.size() > 0) begin
      w = m_q.pop_front();
      if (NL && w == 16'hFFFF) begin
        m_ptr = (((m_ptr / LINE_STEP) + 1) * LINE_STEP) % SPAN;
      end else begin
        exp_we   = 1'b1;
        exp_addr = m_ptr;
        exp_data = w;
        m_ptr    = (m_ptr + STEP) % SPAN;
      end
    end
    if (e) begin
      if (m_q.size() < DEPTH) m_q.push_back(d);
      else exp_ovf = 1'b1;
    end
  endtask

  task automatic cyc(input string ph, input logic e, input logic [15:0] d);
    info   = d;
    info_e = e;
    @(posedge clk);
    model_edge(e, d);
    #1;
    if (we) n_we++;
    check_outputs(ph);
  endtask

  // Asserts reset mid-cycle so the asynchronous clear of all outputs is visible immediately.
  task automatic do_reset();
    @(posedge clk);
    #3;
    rst_n  = 1'b0;
    info_e = 1'b0;
    info   = '0;
    m_clr = 0; m_ptr = 0; m_q.delete();
    exp_we = 1'b0; exp_addr = 0; exp_data = '0; exp_busy = 1'b1; exp_ovf = 1'b0;
    n_we = 0;
    #1;
    check_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic idle(input string ph, input int n);
    for (int i = 0; i < n; i++) cyc(ph, 1'b0, 16'h0000);
  endtask

  initial begin
    logic [15:0] r;

    // Clear sweep length, then two back-to-back words.
    do_reset();
    idle("clear", NCLR);
    chk("clear_write_count", 32'(n_we), 32'(NCLR));
    idle("post_clear", 2);
    cyc("push1", 1'b1, 16'h1234);
    cyc("push2", 1'b1, 16'hABCD);
    idle("drain_a", 4);

    // Three words pushed during clear are held until RUN.
    do_reset();
    cyc("held1", 1'b1, 16'h0A01);
    cyc("held2", 1'b1, 16'h0A02);
    cyc("held3", 1'b1, 16'h0A03);
    idle("held_clear", NCLR - 3 + 5);

    // Nine words into depth eight during clear: the ninth is dropped.
    do_reset();
    for (int i = 0; i < 9; i++) cyc("ovf_push", 1'b1, 16'(16'h0B00 + i));
    idle("ovf_clear", NCLR - 9 + 12);

    // Full FIFO with a simultaneous pop accepts the push.
    do_reset();
    for (int i = 0; i < DEPTH; i++) cyc("fill", 1'b1, 16'(16'h0C00 + i));
    idle("fill_clear", NCLR - DEPTH);
    for (int i = 0; i < 10; i++) cyc("full_pop", 1'b1, 16'(16'h0D00 + i));
    idle("fill_drain", 12);

    // Address wrap: 33 words after clear.
    do_reset();
    idle("wrap_clear", NCLR);
    for (int i = 0; i < NCLR + 1; i++) cyc("wrap", 1'b1, 16'(16'h1000 + i));
    idle("wrap_drain", 3);

    // Newline marker handling.
    do_reset();
    idle("nl_clear", NCLR);
    cyc("nl_a", 1'b1, 16'h1111);
    cyc("nl_mark", 1'b1, 16'hFFFF);
    cyc("nl_b", 1'b1, 16'h2222);
    cyc("nl_mark2", 1'b1, 16'hFFFF);
    idle("nl_drain", 4);

    // Random traffic with a mid-operation reset.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if (i == 150) do_reset();
      r = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom_range(0, 16'hFFFE));
      cyc("rand", ($urandom_range(0, 3) != 0), r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
